// File: rtl/virtio_available_ring_reader_if.sv
// virtio_available_ring_reader_if
//
// Bundles every non-clock signal of virtio_available_ring_reader.
//   slave  : the reader itself (consumes requests/config/read data,
//            produces memory reads, idx/event updates and the id stream).
//   master : the surrounding logic (handler, memory agent, descriptor stage).
//
// Groups:
//   configure_*         ring base address (bytes) and queue size
//   req_*               handler request: type, free-running offset, length
//   rd_*                16-bit-word memory read burst request
//   rdata_*             memory read data, one 16-bit word per beat
//   resp_*              avail idx update back to the handler
//   event_*             used_event value pulse
//   id_*                descriptor head id stream (with burst-last flag)
//   error               sticky id-range error
interface virtio_available_ring_reader_if;
  logic        configure_valid;
  logic [63:0] configure_base;
  logic [15:0] configure_size;

  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_type;
  logic [15:0] req_offset;
  logic [15:0] req_length;

  logic        rd_valid;
  logic        rd_ready;
  logic [63:0] rd_addr;
  logic [15:0] rd_words;

  logic        rdata_valid;
  logic [15:0] rdata;
  logic        rdata_ready;

  logic        resp_valid;
  logic [15:0] resp_offset;

  logic        event_valid;
  logic [15:0] event_idx;

  logic        id_valid;
  logic        id_ready;
  logic [15:0] id;
  logic        id_last;

  logic        error;

  modport slave (
    input  configure_valid, configure_base, configure_size,
    input  req_valid, req_type, req_offset, req_length,
    output req_ready,
    output rd_valid, rd_addr, rd_words,
    input  rd_ready,
    input  rdata_valid, rdata,
    output rdata_ready,
    output resp_valid, resp_offset,
    output event_valid, event_idx,
    output id_valid, id, id_last,
    input  id_ready,
    output error
  );

  modport master (
    output configure_valid, configure_base, configure_size,
    output req_valid, req_type, req_offset, req_length,
    input  req_ready,
    input  rd_valid, rd_addr, rd_words,
    output rd_ready,
    output rdata_valid, rdata,
    input  rdata_ready,
    input  resp_valid, resp_offset,
    input  event_valid, event_idx,
    input  id_valid, id, id_last,
    output id_ready,
    input  error
  );
endinterface

// File: rtl/virtio_available_ring_reader.sv
// virtio_available_ring_reader
//
// Turns available-ring handler requests (read avail idx, read used_event,
// read N ring entries) into 16-bit-word memory read bursts against the
// configured available ring. The avail idx goes back to the handler as a
// write-pointer update, used_event is emitted as a pulse, and ring entries
// (descriptor head ids) are queued in an internal FIFO for the
// descriptor-chain stage.
//
// Ports:
//   aclk    clock
//   areset  synchronous active-high reset
//   bus     virtio_available_ring_reader_if.slave (config, request, memory
//           read, read data, idx response, event, id stream, error)
//
// Parameters:
//   MAX_BURST_TRANSACTIONS  largest READ_IDS length the handler issues
//   FIFO_DEPTH              id FIFO depth, power of 2, >= MAX_BURST_TRANSACTIONS
//
// Optional feature macro: VIRTIO_AVAILABLE_RING_READER_ID_CHECK_EN
//   defined   : ids >= queue size are dropped (reservation released) and
//               the sticky error output is raised
//   undefined : ids pass unchecked, error tied to 0
module virtio_available_ring_reader #(
  parameter int MAX_BURST_TRANSACTIONS = 16,
  parameter int FIFO_DEPTH             = 32
) (
  input logic                           aclk,
  input logic                           areset,
  virtio_available_ring_reader_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] TYPE_IDX   = 2'd0;
  localparam logic [1:0] TYPE_EVENT = 2'd1;
  localparam logic [1:0] TYPE_IDS   = 2'd2;

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_ISSUE_FIRST  = 2'd1;
  localparam logic [1:0] S_ISSUE_SECOND = 2'd2;
  localparam logic [1:0] S_WAIT_DATA    = 2'd3;

  if (MAX_BURST_TRANSACTIONS < 1 || MAX_BURST_TRANSACTIONS > FIFO_DEPTH ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("virtio_available_ring_reader: illegal MAX_BURST_TRANSACTIONS/FIFO_DEPTH");
  end

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Ring configuration; only sampled when a request is accepted.
  logic [63:0] cfg_base;
  logic [15:0] cfg_size;

  logic [1:0]  state;
  logic [1:0]  cur_type;
  logic        split_pending;
  logic [63:0] second_addr;
  logic [15:0] second_words;
  logic [15:0] beats_left;
  logic [63:0] rd_addr_r;
  logic [15:0] rd_words_r;

  logic        resp_vld_p1;
  logic [15:0] resp_data_p1;
  logic        event_vld_p1;
  logic [15:0] event_data_p1;

  logic [16:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] reserved;

  // Request decode and burst address math.
  logic [16:0] free_slots;
  logic        req_ready_c;
  logic        accept;
  logic [15:0] idx0;
  logic [16:0] idx_end;
  logic        do_split;
  logic [15:0] first_words;
  logic [63:0] ring_base;
  logic [63:0] ids_addr;
  logic [63:0] event_addr;
  logic [CNT_W-1:0] resv_add;

  assign free_slots  = 17'(FIFO_DEPTH) - 17'(count) - 17'(reserved);
  assign req_ready_c = !areset && (state == S_IDLE) &&
                       (bus.req_type != TYPE_IDS || {1'b0, bus.req_length} <= free_slots);
  assign accept      = bus.req_valid && req_ready_c;

  assign idx0        = bus.req_offset & (cfg_size - 16'd1);
  assign idx_end     = {1'b0, idx0} + {1'b0, bus.req_length};
  assign do_split    = idx_end > {1'b0, cfg_size};
  assign first_words = do_split ? (cfg_size - idx0) : bus.req_length;
  assign ring_base   = cfg_base + 64'd4;
  assign ids_addr    = ring_base + {47'd0, idx0, 1'b0};
  assign event_addr  = ring_base + {47'd0, cfg_size, 1'b0};
  // Accepted lengths never exceed free_slots <= FIFO_DEPTH, so this fits.
  assign resv_add    = (accept && bus.req_type == TYPE_IDS) ? CNT_W'(bus.req_length) : '0;

  // Read data beats. Beats of the first burst may land while the second
  // burst is still being issued, so any non-IDLE state counts them.
  logic beat;
  logic final_beat;
  logic ids_beat;
  logic id_bad;
  logic fifo_wr;
  logic fifo_rd;
  logic id_vld;

  assign beat       = bus.rdata_valid && (state != S_IDLE);
  assign final_beat = beat && (beats_left == 16'd1);
  assign ids_beat   = beat && (cur_type == TYPE_IDS);
  assign fifo_wr    = ids_beat && !id_bad;
  assign id_vld     = (count != '0);
  assign fifo_rd    = id_vld && bus.id_ready;

  always_ff @(posedge aclk) begin
    if (bus.configure_valid) begin
      cfg_base <= bus.configure_base;
      cfg_size <= bus.configure_size;
    end
  end

  // ---- request acceptance / burst issue / beat counting ----
  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= S_IDLE;
      split_pending <= 1'b0;
      rd_addr_r     <= '0;
      rd_words_r    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cur_type <= bus.req_type;
            case (bus.req_type)
              TYPE_IDX: begin
                rd_addr_r     <= cfg_base + 64'd2;
                rd_words_r    <= 16'd1;
                beats_left    <= 16'd1;
                split_pending <= 1'b0;
                state         <= S_ISSUE_FIRST;
              end
              TYPE_EVENT: begin
                rd_addr_r     <= event_addr;
                rd_words_r    <= 16'd1;
                beats_left    <= 16'd1;
                split_pending <= 1'b0;
                state         <= S_ISSUE_FIRST;
              end
              TYPE_IDS: begin
                // Zero-length reads touch no memory.
                if (bus.req_length != 16'd0) begin
                  rd_addr_r     <= ids_addr;
                  rd_words_r    <= first_words;
                  second_addr   <= ring_base;
                  second_words  <= bus.req_length - first_words;
                  split_pending <= do_split;
                  beats_left    <= bus.req_length;
                  state         <= S_ISSUE_FIRST;
                end
              end
              default: ;
            endcase
          end
        end
        S_ISSUE_FIRST: begin
          if (bus.rd_ready) begin
            if (split_pending) begin
              rd_addr_r  <= second_addr;
              rd_words_r <= second_words;
              state      <= S_ISSUE_SECOND;
            end else begin
              state <= S_WAIT_DATA;
            end
          end
        end
        S_ISSUE_SECOND: begin
          if (bus.rd_ready) state <= S_WAIT_DATA;
        end
        default: ;
      endcase

      if (beat) begin
        beats_left <= beats_left - 16'd1;
        if (final_beat) state <= S_IDLE;
      end
    end
  end

  // ---- beat -> idx / used_event outputs (registered pulse) ----
  always_ff @(posedge aclk) begin
    if (areset) begin
      resp_vld_p1   <= 1'b0;
      resp_data_p1  <= '0;
      event_vld_p1  <= 1'b0;
      event_data_p1 <= '0;
    end else begin
      resp_vld_p1  <= beat && (cur_type == TYPE_IDX);
      event_vld_p1 <= beat && (cur_type == TYPE_EVENT);
      if (beat && cur_type == TYPE_IDX)   resp_data_p1  <= bus.rdata;
      if (beat && cur_type == TYPE_EVENT) event_data_p1 <= bus.rdata;
    end
  end

  // ---- id FIFO ----
  always_ff @(posedge aclk) begin
    if (fifo_wr) fifo_mem[wptr] <= {final_beat, bus.rdata};
  end

  // Every ids beat releases one reservation, whether it is stored or dropped.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      reserved <= '0;
    end else begin
      if (fifo_wr) wptr <= ptr_next(wptr);
      if (fifo_rd) rptr <= ptr_next(rptr);
      case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      reserved <= reserved + resv_add - CNT_W'(ids_beat);
    end
  end

`ifdef VIRTIO_AVAILABLE_RING_READER_ID_CHECK_EN
  logic [15:0] cur_size;
  logic        error_r;

  assign id_bad = bus.rdata >= cur_size;

  always_ff @(posedge aclk) begin
    if (accept) cur_size <= cfg_size;
  end

  always_ff @(posedge aclk) begin
    if (areset)                 error_r <= 1'b0;
    else if (ids_beat && id_bad) error_r <= 1'b1;
  end

  assign bus.error = error_r;
`else
  assign id_bad    = 1'b0;
  assign bus.error = 1'b0;
`endif

  assign bus.req_ready   = req_ready_c;
  assign bus.rd_valid    = (state == S_ISSUE_FIRST) || (state == S_ISSUE_SECOND);
  assign bus.rd_addr     = rd_addr_r;
  assign bus.rd_words    = rd_words_r;
  assign bus.rdata_ready = 1'b1;
  assign bus.resp_valid  = resp_vld_p1;
  assign bus.resp_offset = resp_data_p1;
  assign bus.event_valid = event_vld_p1;
  assign bus.event_idx   = event_data_p1;
  assign bus.id_valid    = id_vld;
  assign bus.id          = id_vld ? fifo_mem[rptr][15:0] : 16'd0;
  assign bus.id_last     = id_vld ? fifo_mem[rptr][16] : 1'b0;

endmodule

// File: tb/tb_virtio_available_ring_reader.sv
`timescale 1ns/1ps
module tb_virtio_available_ring_reader;
  localparam int FIFO_DEPTH = 32;
  localparam logic [1:0] T_IDX = 2'd0, T_EVT = 2'd1, T_IDS = 2'd2, T_RSV = 2'd3;

  logic aclk = 1'b0;
  logic areset;
  virtio_available_ring_reader_if bus();

  virtio_available_ring_reader #(
    .MAX_BURST_TRANSACTIONS(16),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .bus(bus)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_rd_addr_q[$];
  logic [15:0] exp_rd_words_q[$];
  logic [15:0] mem_data_q[$];
  logic [15:0] beat_q[$];
  logic [15:0] exp_resp_q[$];
  logic [15:0] exp_event_q[$];
  logic [16:0] exp_id_q[$];
  bit rd_stall = 1'b0;
  bit beat_stall = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Memory agent and output scoreboard; samples mid-cycle, drives for the next edge.
  initial begin
    logic [16:0] e;
    logic [15:0] w;
    bus.rdata_valid = 1'b0;
    bus.rdata = '0;
    bus.rd_ready = 1'b0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        exp_rd_addr_q.delete(); exp_rd_words_q.delete(); mem_data_q.delete();
        beat_q.delete(); exp_resp_q.delete(); exp_event_q.delete(); exp_id_q.delete();
        bus.rdata_valid = 1'b0;
        bus.rd_ready = 1'b0;
      end else begin
        if (bus.resp_valid) begin
          if (exp_resp_q.size() == 0) check("resp_unexpected", 1, 0);
          else check("resp_offset", bus.resp_offset, exp_resp_q.pop_front());
        end
        if (bus.event_valid) begin
          if (exp_event_q.size() == 0) check("event_unexpected", 1, 0);
          else check("event_idx", bus.event_idx, exp_event_q.pop_front());
        end
        if (bus.id_valid && bus.id_ready) begin
          if (exp_id_q.size() == 0) check("id_unexpected", 1, 0);
          else begin
            e = exp_id_q.pop_front();
            check("id", bus.id, e[15:0]);
            check("id_last", bus.id_last, e[16]);
          end
        end
        if (beat_q.size() > 0 && !(beat_stall && $urandom_range(0, 2) == 0)) begin
          bus.rdata_valid = 1'b1;
          bus.rdata = beat_q.pop_front();
        end else begin
          bus.rdata_valid = 1'b0;
          bus.rdata = 16'hDEAD;
        end
        bus.rd_ready = rd_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.rd_valid && bus.rd_ready) begin
          if (exp_rd_addr_q.size() == 0) check("rd_unexpected", 1, 0);
          else begin
            check("rd_addr", bus.rd_addr, exp_rd_addr_q.pop_front());
            w = exp_rd_words_q.pop_front();
            check("rd_words", bus.rd_words, w);
            for (int n = 0; n < int'(bus.rd_words); n++) begin
              if (mem_data_q.size() == 0) break;
              beat_q.push_back(mem_data_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_cfg(input logic [63:0] base, input logic [15:0] size);
    bus.configure_valid = 1'b1;
    bus.configure_base = base;
    bus.configure_size = size;
    tick();
    bus.configure_valid = 1'b0;
  endtask

  task automatic do_req(input logic [1:0] t, input logic [15:0] off, input logic [15:0] len);
    int n;
    bus.req_valid = 1'b1;
    bus.req_type = t;
    bus.req_offset = off;
    bus.req_length = len;
    n = 0;
    forever begin
      @(negedge aclk);
      if (bus.req_ready) break;
      n++;
      if (n > 300) begin
        check("req_accept_timeout", 0, 1);
        break;
      end
    end
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit with_ids);
    int n;
    n = 0;
    forever begin
      @(negedge aclk);
      if (exp_rd_addr_q.size() == 0 && beat_q.size() == 0 && mem_data_q.size() == 0 &&
          exp_resp_q.size() == 0 && exp_event_q.size() == 0 && !bus.rd_valid &&
          (!with_ids || exp_id_q.size() == 0)) break;
      n++;
      if (n > 500) begin
        check("drain_timeout", 0, 1);
        break;
      end
    end
    tick();
    tick();
  endtask

  // Ring-layout model for READ_IDS: expected bursts plus random in-range ids.
  task automatic expect_ids(input logic [63:0] base, input int size, input int off, input int len);
    int idx0, first;
    logic [15:0] d;
    idx0 = off & (size - 1);
    first = (idx0 + len > size) ? size - idx0 : len;
    exp_rd_addr_q.push_back(base + 64'(4 + 2 * idx0));
    exp_rd_words_q.push_back(16'(first));
    if (len > first) begin
      exp_rd_addr_q.push_back(base + 64'd4);
      exp_rd_words_q.push_back(16'(len - first));
    end
    for (int i = 0; i < len; i++) begin
      d = 16'($urandom_range(0, size - 1));
      mem_data_q.push_back(d);
      exp_id_q.push_back({(i == len - 1), d});
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    bus.configure_valid = 1'b0;
    bus.configure_base = '0;
    bus.configure_size = '0;
    bus.req_valid = 1'b0;
    bus.req_type = T_IDX;
    bus.req_offset = '0;
    bus.req_length = '0;
    bus.id_ready = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_event_valid", bus.event_valid, 0);
    check("rst_id_valid", bus.id_valid, 0);
    check("rst_error", bus.error, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_rd_words", bus.rd_words, 0);
    check("rst_id", {bus.id_last, bus.id}, 0);
    check("rst_outputs", {bus.resp_offset, bus.event_idx}, 0);
    tick();
    areset = 1'b0;
    @(negedge aclk);
    check("idle_req_ready", bus.req_ready, 1);
    check("rdata_ready", bus.rdata_ready, 1);
    tick();

    do_cfg(64'h1000, 16'd256);
    bus.id_ready = 1'b1;

    // READ_IDX
    exp_rd_addr_q.push_back(64'h1002); exp_rd_words_q.push_back(16'd1);
    mem_data_q.push_back(16'h0005); exp_resp_q.push_back(16'd5);
    do_req(T_IDX, 16'd0, 16'd0);
    @(negedge aclk);
    check("rd_valid_latency", bus.rd_valid, 1);
    tick();
    wait_idle(1'b1);

    // READ_USED_EVENT
    exp_rd_addr_q.push_back(64'h1204); exp_rd_words_q.push_back(16'd1);
    mem_data_q.push_back(16'h0042); exp_event_q.push_back(16'h0042);
    do_req(T_EVT, 16'd0, 16'd0);
    wait_idle(1'b1);

    // READ_IDS, single burst
    exp_rd_addr_q.push_back(64'h100A); exp_rd_words_q.push_back(16'd4);
    for (int i = 7; i <= 10; i++) begin
      mem_data_q.push_back(16'(i));
      exp_id_q.push_back({(i == 10), 16'(i)});
    end
    do_req(T_IDS, 16'h0103, 16'd4);
    wait_idle(1'b1);

    // READ_IDS, wrapping split burst
    exp_rd_addr_q.push_back(64'h1200); exp_rd_words_q.push_back(16'd2);
    exp_rd_addr_q.push_back(64'h1004); exp_rd_words_q.push_back(16'd3);
    for (int i = 20; i <= 24; i++) begin
      mem_data_q.push_back(16'(i));
      exp_id_q.push_back({(i == 24), 16'(i)});
    end
    do_req(T_IDS, 16'd254, 16'd5);
    wait_idle(1'b1);

    // Zero-length READ_IDS and reserved type: accepted, no memory access.
    do_req(T_IDS, 16'd5, 16'd0);
    do_req(T_RSV, 16'd0, 16'd3);
    repeat (4) tick();
    @(negedge aclk);
    check("no_access_rd_valid", bus.rd_valid, 0);
    check("no_access_req_ready", bus.req_ready, 1);
    tick();

    // FIFO reservation backpressure.
    bus.id_ready = 1'b0;
    exp_rd_addr_q.push_back(64'h1004); exp_rd_words_q.push_back(16'd16);
    exp_rd_addr_q.push_back(64'h1024); exp_rd_words_q.push_back(16'd4);
    for (int i = 100; i <= 119; i++) begin
      mem_data_q.push_back(16'(i));
      exp_id_q.push_back({(i == 115 || i == 119), 16'(i)});
    end
    do_req(T_IDS, 16'd0, 16'd16);
    do_req(T_IDS, 16'd16, 16'd4);
    wait_idle(1'b0);
    bus.req_type = T_IDS;
    bus.req_length = 16'd16;
    @(negedge aclk);
    check("fifo_held_req_ready", bus.req_ready, 0);
    check("fifo_held_id_valid", bus.id_valid, 1);
    tick();
    bus.id_ready = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
    bus.id_ready = 1'b0;
    @(negedge aclk);
    check("after_pop_req_ready", bus.req_ready, 1);
    tick();
    bus.req_length = 16'd17;
    @(negedge aclk);
    check("over_free_req_ready", bus.req_ready, 0);
    tick();
    bus.id_ready = 1'b1;
    wait_idle(1'b1);

    // Random requests, wrapping 64-bit base, memory-side stalls.
    rd_stall = 1'b1;
    beat_stall = 1'b1;
    do_cfg(64'hFFFF_FFFF_FFFF_FFF0, 16'd16);
    exp_rd_addr_q.push_back(64'hFFFF_FFFF_FFFF_FFF2); exp_rd_words_q.push_back(16'd1);
    mem_data_q.push_back(16'h1234); exp_resp_q.push_back(16'h1234);
    do_req(T_IDX, 16'd0, 16'd0);
    for (int k = 0; k < 8; k++) begin
      int off, len;
      off = $urandom_range(0, 65535);
      len = $urandom_range(1, 16);
      expect_ids(64'hFFFF_FFFF_FFFF_FFF0, 16, off, len);
      do_req(T_IDS, 16'(off), 16'(len));
    end
    wait_idle(1'b1);
    rd_stall = 1'b0;
    beat_stall = 1'b0;

`ifdef VIRTIO_AVAILABLE_RING_READER_ID_CHECK_EN
    // Out-of-range id dropped, error sticky, reservation returned.
    do_cfg(64'h1000, 16'd8);
    exp_rd_addr_q.push_back(64'h1004); exp_rd_words_q.push_back(16'd2);
    mem_data_q.push_back(16'd3); mem_data_q.push_back(16'd9);
    exp_id_q.push_back({1'b0, 16'd3});
    do_req(T_IDS, 16'd0, 16'd2);
    wait_idle(1'b1);
    bus.req_type = T_IDS;
    bus.req_length = 16'd32;
    repeat (3) tick();
    @(negedge aclk);
    check("id_check_error", bus.error, 1);
    check("id_check_slots_free", bus.req_ready, 1);
    tick();
`else
    @(negedge aclk);
    check("error_tied_low", bus.error, 0);
    tick();
`endif

    // Reset in the middle of a burst.
    bus.id_ready = 1'b0;
    do_cfg(64'h1000, 16'd256);
    expect_ids(64'h1000, 256, 0, 8);
    do_req(T_IDS, 16'd0, 16'd8);
    repeat (4) tick();
    areset = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check("midrst_rd_valid", bus.rd_valid, 0);
    check("midrst_id_valid", bus.id_valid, 0);
    check("midrst_req_ready", bus.req_ready, 0);
    check("midrst_error", bus.error, 0);
    check("midrst_addr", {bus.rd_addr, bus.rd_words}, 0);
    check("midrst_pulses", {bus.resp_valid, bus.event_valid, bus.id_last, bus.id}, 0);
    tick();
    areset = 1'b0;
    bus.id_ready = 1'b1;
    @(negedge aclk);
    check("postrst_req_ready", bus.req_ready, 1);
    check("postrst_fifo_empty", bus.id_valid, 0);
    tick();
    do_cfg(64'h1000, 16'd256);
    exp_rd_addr_q.push_back(64'h1002); exp_rd_words_q.push_back(16'd1);
    mem_data_q.push_back(16'h0077); exp_resp_q.push_back(16'h0077);
    do_req(T_IDX, 16'd0, 16'd0);
    wait_idle(1'b1);

    check("leftover_rd", exp_rd_addr_q.size(), 0);
    check("leftover_ids", exp_id_q.size(), 0);
    check("leftover_resp", exp_resp_q.size() + exp_event_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
